// File: rtl/cache_fill_fsm.sv
// Cache block fill sequencer: on a tag miss, issues one read per word of the
// block, writes each returned word into the data array in arrival order, and
// writes the tag/valid bit together with the last word.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        data_word_sel,
  output logic              write_tag_array
);

  localparam int WSEL_W = $clog2(BLOCK_WORDS);   // word index width
  localparam int OFF_W  = WSEL_W + 1;            // byte offset within a block
  localparam int CNT_W  = WSEL_W + 1;            // issue count must reach BLOCK_WORDS
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BLOCK_WORDS);
  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(BLOCK_WORDS - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_base, w_base_nxt;
  logic [CNT_W-1:0]   r_issue_cnt, w_issue_nxt;
  logic [WSEL_W-1:0]  r_rx_cnt, w_rx_nxt;

  // State, block base and the two independent counters (requests issued,
  // words received); issue and return are decoupled so any latency works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_issue_cnt <= w_issue_nxt;
      r_rx_cnt    <= w_rx_nxt;
    end
  end

  // Next-state and outputs; every output is forced low while reset is held,
  // since busy also depends combinationally on miss_detected.
  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_issue_nxt      = r_issue_cnt;
    w_rx_nxt         = r_rx_cnt;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_sel    = '0;
    write_tag_array  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Stall the CPU in the miss cycle itself; returns here are ignored.
        if (miss_detected) begin
          fsm_busy    = 1'b1;
          w_state_nxt = S_FILL;
          w_base_nxt  = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          w_issue_nxt = '0;
          w_rx_nxt    = '0;
        end
      end
      S_FILL: begin
        fsm_busy = 1'b1;
        // Issue counter saturates at BLOCK_WORDS, which idles the read port.
        if (r_issue_cnt < CNT_FULL) begin
          mem_rd_en      = 1'b1;
          memory_address = {r_base[ADDR_W-1:OFF_W], r_issue_cnt[WSEL_W-1:0], 1'b0};
          w_issue_nxt    = r_issue_cnt + 1'b1;
        end
        // Words arrive in request order, so rx_cnt is the word index.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_sel    = r_rx_cnt;
          w_rx_nxt         = r_rx_cnt + 1'b1;
          if (r_rx_cnt == LAST_WORD) begin
            write_tag_array = 1'b1;
            w_state_nxt     = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (!rst_n) begin
      fsm_busy         = 1'b0;
      mem_rd_en        = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      data_word_sel    = '0;
      write_tag_array  = 1'b0;
    end
  end

endmodule
